// File: rtl/ieee754_int_to_float_mc_if.sv
// Handshake bundle for the integer-to-single-precision converter.
// The master side issues requests and consumes results; the slave side is the converter.
interface ieee754_int_to_float_mc_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_int;
  logic        in_unsigned;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        inexact;

  modport master (
    output in_valid, in_int, in_unsigned, out_ready,
    input  in_ready, out_valid, result, inexact
  );

  modport slave (
    input  in_valid, in_int, in_unsigned, out_ready,
    output in_ready, out_valid, result, inexact
  );
endinterface

// File: rtl/ieee754_int_to_float_mc.sv
// Multi-cycle 32-bit integer (signed/unsigned) to IEEE-754 single converter (FCVT.S.W/WU).
// Iterative left-normalisation, then one round-to-nearest-even cycle.
module ieee754_int_to_float_mc #(
  parameter int SHIFT_STEP = 1
) (
  input logic                       clk,
  input logic                       rst_n,
  ieee754_int_to_float_mc_if.slave  bus
);

  localparam logic [4:0] STEP_AMT = 5'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] mag_reg;
  logic [4:0]  sh_reg;
  logic        sign_reg;
  logic [31:0] result_reg;
  logic        inexact_reg;

  logic        accept;
  logic        wide_step_ok;
  logic        in_sign;
  logic [31:0] in_mag;

  logic [22:0] frac_raw;
  logic        guard_bit;
  logic        sticky_bit;
  logic        round_up;
  logic [23:0] mant_sum;
  logic [7:0]  exp_pre;
  logic [7:0]  exp_fin;

  assign accept  = bus.in_valid & (state_reg == IDLE);
  assign in_sign = ~bus.in_unsigned & bus.in_int[31];
  // Negating 0x80000000 wraps to itself, which is the correct magnitude.
  assign in_mag  = in_sign ? (32'd0 - bus.in_int) : bus.in_int;

  // A multi-bit step is only taken when the whole top window is zero, so it never overshoots.
  generate
    if (SHIFT_STEP > 1) begin : g_wide_step
      assign wide_step_ok = ~|mag_reg[31 -: SHIFT_STEP];
    end else begin : g_unit_step
      assign wide_step_ok = 1'b0;
    end
  endgenerate

  assign frac_raw   = mag_reg[30:8];
  assign guard_bit  = mag_reg[7];
  assign sticky_bit = |mag_reg[6:0];
  assign round_up   = guard_bit & (sticky_bit | frac_raw[0]);
  assign mant_sum   = {1'b0, frac_raw} + {23'd0, round_up};
  assign exp_pre    = 8'd158 - {3'b000, sh_reg};
  // A carry out of the fraction leaves mant_sum[22:0] all zero and bumps the exponent.
  assign exp_fin    = exp_pre + {7'd0, mant_sum[23]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (accept) state_next = (bus.in_int == 32'd0) ? DONE : NORM;
      NORM:  if (mag_reg[31]) state_next = ROUND;
      ROUND: state_next = DONE;
      DONE:  if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_reg == IDLE);
    bus.out_valid = (state_reg == DONE);
    bus.result    = result_reg;
    bus.inexact   = inexact_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_reg     <= 32'd0;
      sh_reg      <= 5'd0;
      sign_reg    <= 1'b0;
      result_reg  <= 32'd0;
      inexact_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            sign_reg <= in_sign;
            mag_reg  <= in_mag;
            sh_reg   <= 5'd0;
            if (bus.in_int == 32'd0) begin
              result_reg  <= 32'd0;
              inexact_reg <= 1'b0;
            end
          end
        end
        NORM: begin
          if (!mag_reg[31]) begin
            if (wide_step_ok) begin
              mag_reg <= mag_reg << SHIFT_STEP;
              sh_reg  <= sh_reg + STEP_AMT;
            end else begin
              mag_reg <= mag_reg << 1;
              sh_reg  <= sh_reg + 5'd1;
            end
          end
        end
        ROUND: begin
          result_reg  <= {sign_reg, exp_fin, mant_sum[22:0]};
          inexact_reg <= guard_bit | sticky_bit;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ieee754_int_to_float_mc.sv
// Directed-vector bench for ieee754_int_to_float_mc (SHIFT_STEP=1).
// Latency is counted in rising edges after the accept edge.
module tb_ieee754_int_to_float_mc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ieee754_int_to_float_mc_if bus ();

  ieee754_int_to_float_mc #(.SHIFT_STEP(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic convert(input string tag, input logic [31:0] val, input logic uns,
                         input logic [31:0] exp_res, input logic exp_nx, input int exp_lat);
    int guard;
    int lat;
    @(negedge clk);
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid    = 1'b1;
    bus.in_int      = val;
    bus.in_unsigned = uns;
    @(posedge clk);
    #1;
    bus.in_valid    = 1'b0;
    bus.in_int      = $urandom;
    bus.in_unsigned = 1'($urandom_range(0, 1));
    @(negedge clk);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_result"}, bus.result, exp_res);
    chk({tag, "_inexact"}, {31'd0, bus.inexact}, {31'd0, exp_nx});
    chk({tag, "_latency"}, lat, exp_lat);
    $display("conv %-10s in=0x%08h uns=%0d -> 0x%08h nx=%0d lat=%0d", tag, val, uns,
             bus.result, bus.inexact, lat);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_drop"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    bus.in_valid    = 1'b0;
    bus.in_int      = 32'd0;
    bus.in_unsigned = 1'b0;
    bus.out_ready   = 1'b1;

    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_inexact", {31'd0, bus.inexact}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    convert("s_one",    32'h00000001, 1'b0, 32'h3F800000, 1'b0, 33);
    convert("s_m1",     32'hFFFFFFFF, 1'b0, 32'hBF800000, 1'b0, 33);
    convert("s_min",    32'h80000000, 1'b0, 32'hCF000000, 1'b0, 2);
    convert("u_max",    32'hFFFFFFFF, 1'b1, 32'h4F800000, 1'b1, 2);
    convert("s_tie_ev", 32'h01000001, 1'b0, 32'h4B800000, 1'b1, 9);
    convert("s_tie_up", 32'h01000003, 1'b0, 32'h4B800002, 1'b1, 9);
    convert("s_max",    32'h7FFFFFFF, 1'b0, 32'h4F000000, 1'b1, 3);
    convert("u_msb",    32'h80000000, 1'b1, 32'h4F000000, 1'b0, 2);
    convert("s_m100",   32'hFFFFFF9C, 1'b0, 32'hC2C80000, 1'b0, 27);
    // The zero result is written by the accept edge itself, so DONE is seen right after it.
    convert("zero",     32'h00000000, 1'b0, 32'h00000000, 1'b0, 0);

    // Zero again, this time holding the result with out_ready low while a new request knocks.
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_int   = 32'h00000000;
    @(posedge clk);
    #1;
    bus.in_int = 32'h12345678;
    @(negedge clk);
    held = bus.result;
    chk("hold_first_valid", {31'd0, bus.out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold_result", bus.result, 32'h00000000);
      chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    $display("hold result=0x%08h (captured 0x%08h) over 5 stalled cycles", bus.result, held);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("handoff_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("handoff_out_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.in_valid = 1'b0;

    // Reset in the middle of normalisation drops the operation.
    bus.in_valid    = 1'b1;
    bus.in_int      = 32'h00000001;
    bus.in_unsigned = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy", {31'd0, bus.in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_result", bus.result, 32'd0);
    $display("mid-NORM reset: in_ready=%0d out_valid=%0d result=0x%08h",
             bus.in_ready, bus.out_valid, bus.result);
    @(negedge clk);
    rst_n = 1'b1;

    convert("s_100",    32'h00000064, 1'b0, 32'h42C80000, 1'b0, 27);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
